instr_fetch_unit: RTL and testbench

Fetch stage that sits directly upstream of decode and the immediate extender. It owns the fetch PC and issues one-at-a-time requests to instruction memory. Returned words go into a small prefetch FIFO, and the unit presents Instr/PC/PCPlus4 to decode over a valid/ready handshake. Branch/jump redirects flush the FIFO and discard any in-flight response.

---
 rtl/riscv_fetch_pkg.sv | 9 +
 rtl/instr_fetch_fifo.sv | 40 ++++
 rtl/instr_fetch_unit.sv | 92 +++++++++
 tb/tb_instr_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared constants and types for the instruction fetch unit
package riscv_fetch_pkg;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_e;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: synchronous power-of-two FIFO with flush and occupancy count
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [CW-1:0]    count_o,
   output logic             empty_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0] rd_q, wr_q;
   logic [CW-1:0] count_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_q <= '0;
         wr_q <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         rd_q <= '0;
         wr_q <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i) rd_q <= rd_q + 1'b1;
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   always_ff @(posedge clk)
      if (push_i && !flush_i) mem_q[wr_q] <= din_i;
   assign dout_o = mem_q[rd_q];
   assign count_o = count_q;
   assign empty_o = count_q == '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, one-outstanding imem requests and prefetch FIFO to decode
// Optional FETCH_PERF_EN adds the fetch_stall_cycles counter output.
module instr_fetch_unit import riscv_fetch_pkg::*; #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        fetch_misalign
`ifdef FETCH_PERF_EN
   ,output logic [31:0] fetch_stall_cycles
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   fetch_state_e state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
   logic [CW-1:0] count;
   logic empty, push, pop, fire;
   fetch_entry_t head, wr;
   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .din_i   (wr),
      .dout_o  (head),
      .count_o (count),
      .empty_o (empty)
   );
   // Reset gating keeps every request-side output low while reset is held.
   assign imem_req = !reset && state_q == IDLE && count != CW'(FIFO_DEPTH) && !redirect_valid;
   assign imem_addr = reset ? '0 : fetch_pc_q;
   assign fire = imem_req && imem_ready;
   assign wr = '{instr: imem_rdata, pc: req_pc_q};
   assign instr_valid = !empty;
   assign pop = instr_valid && instr_ready;
   assign Instr = empty ? NOP_INSTR : head.instr;
   assign PC = empty ? '0 : head.pc;
   assign PCPlus4 = PC + 32'd4;
   assign fetch_misalign = !reset && redirect_valid && redirect_pc[1:0] != 2'b00;
   always_comb begin
      state_d = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d = req_pc_q;
      push = 1'b0;
      case (state_q)
         IDLE: if (fire) begin
            state_d = WAIT;
            req_pc_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         WAIT: begin
            push = imem_rvalid && !redirect_valid;
            state_d = imem_rvalid ? IDLE : redirect_valid ? DROP : WAIT;
         end
         // The stale response retires DROP even if another redirect lands with it.
         DROP: state_d = imem_rvalid ? IDLE : DROP;
         default: state_d = IDLE;
      endcase
      if (redirect_valid) fetch_pc_d = {redirect_pc[31:2], 2'b00};
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q <= '0;
      end else begin
         state_q <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q <= req_pc_d;
      end
`ifdef FETCH_PERF_EN
   logic [31:0] stall_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) stall_q <= '0;
      else if (instr_ready && !instr_valid && stall_q != '1) stall_q <= stall_q + 32'd1;
   assign fetch_stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized self-checking bench with a stream-level fetch model
module tb_instr_fetch_unit;
   logic clk = 1'b0, reset = 1'b1;
   logic imem_req, imem_ready, imem_rvalid, redirect_valid, instr_valid, instr_ready, fetch_misalign;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, Instr, PC, PCPlus4;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_stall_cycles;
`endif
   int tests = 0, fails = 0;
   int lat = 1, mem_cnt = 0, pops = 0, accs = 0;
   logic rnd_ready = 1'b0, mem_pend = 1'b0, acc_last = 1'b0, chk_inval = 1'b0;
   logic [31:0] mem_addr = '0, exp_addr = '0, exp_pc = '0;

   instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .Instr          (Instr),
      .PC             (PC),
      .PCPlus4        (PCPlus4),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .fetch_misalign (fetch_misalign)
`ifdef FETCH_PERF_EN
      ,.fetch_stall_cycles (fetch_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Decode should see an unbroken +4 stream starting at the last target; memory data is addr^A5A50000.
   task automatic cycle(input logic dr, input logic rd, input logic [31:0] rpc);
      logic acc, rv;
      logic [31:0] a;
      instr_ready = dr;
      redirect_valid = rd;
      redirect_pc = rpc;
      imem_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      rv = mem_pend && mem_cnt == 0;
      imem_rvalid = rv;
      imem_rdata = mem_addr ^ 32'hA5A5_0000;
      @(negedge clk);
      tests++;
      if (fetch_misalign !== (rd && rpc[1:0] != 2'b00)) begin
         fails++;
         $display("FAIL misalign: got %b expected %b", fetch_misalign, rd && rpc[1:0] != 2'b00);
      end
      if (chk_inval) begin
         tests++;
         if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL valid_after_redirect: got %b expected 0", instr_valid);
         end
      end
      if (mem_pend) begin
         tests++;
         if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL req_while_outstanding: got %b expected 0", imem_req);
         end
      end
      tests++;
      if (instr_valid) begin
         if (PC !== exp_pc || Instr !== (exp_pc ^ 32'hA5A5_0000) || PCPlus4 !== exp_pc + 32'd4) begin
            fails++;
            $display("FAIL head: got pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h",
                     PC, Instr, PCPlus4, exp_pc, exp_pc ^ 32'hA5A5_0000, exp_pc + 32'd4);
         end
      end else if (Instr !== 32'h0000_0013 || PC !== 32'h0 || PCPlus4 !== 32'h4) begin
         fails++;
         $display("FAIL empty_head: got instr=%h pc=%h pc4=%h expected 00000013/0/4", Instr, PC, PCPlus4);
      end
      acc = imem_req && imem_ready;
      a = imem_addr;
      if (acc) begin
         tests++;
         if (a !== exp_addr) begin
            fails++;
            $display("FAIL imem_addr: got %h expected %h", a, exp_addr);
         end
         exp_addr += 32'd4;
         accs++;
      end
      if (instr_valid && dr) begin
         pops++;
         exp_pc += 32'd4;
      end
      if (rd) begin
         exp_addr = {rpc[31:2], 2'b00};
         exp_pc = {rpc[31:2], 2'b00};
      end
      chk_inval = rd;
      acc_last = acc;
      @(posedge clk);
      #1;
      if (rv) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (acc) begin
         mem_pend = 1'b1;
         mem_addr = a;
         mem_cnt = lat - 1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      {imem_ready, imem_rvalid, redirect_valid, instr_ready} = '0;
      imem_rdata = '0;
      redirect_pc = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      {mem_pend, chk_inval, acc_last, rnd_ready} = '0;
      exp_addr = '0;
      exp_pc = '0;
      pops = 0;
      accs = 0;
      lat = 1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      {imem_ready, imem_rvalid, redirect_valid, instr_ready} = '0;
      imem_rdata = '0;
      redirect_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || fetch_misalign !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got req=%b addr=%h valid=%b mis=%b expected 0/0/0/0",
                  imem_req, imem_addr, instr_valid, fetch_misalign);
      end
      tests++;
      if (Instr !== 32'h0000_0013 || PC !== 32'h0 || PCPlus4 !== 32'h4) begin
         fails++;
         $display("FAIL reset_head: got instr=%h pc=%h pc4=%h expected 00000013/0/4", Instr, PC, PCPlus4);
      end
      do_reset();
   endtask

   task automatic test_sequential();
      do_reset();
      repeat (12) cycle(1'b1, 1'b0, '0);
      tests++;
      if (pops < 3) begin
         fails++;
         $display("FAIL seq_progress: got %0d pops expected >=3", pops);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      repeat (10) cycle(1'b0, 1'b0, '0);
      tests++;
      if (accs !== 2 || imem_req !== 1'b0 || instr_valid !== 1'b1 || PC !== 32'h0) begin
         fails++;
         $display("FAIL backpressure: got accs=%0d req=%b valid=%b pc=%h expected 2/0/1/0",
                  accs, imem_req, instr_valid, PC);
      end
      repeat (10) cycle(1'b1, 1'b0, '0);
      tests++;
      if (pops < 3) begin
         fails++;
         $display("FAIL drain_progress: got %0d pops expected >=3", pops);
      end
   endtask

   task automatic test_redirect_wait();
      int n = 0;
      do_reset();
      lat = 3;
      cycle(1'b1, 1'b0, '0);
      while (!acc_last && n < 20) begin
         cycle(1'b1, 1'b0, '0);
         n++;
      end
      tests++;
      if (!acc_last) begin
         fails++;
         $display("FAIL redir_wait_timeout: got no request expected one");
      end
      pops = 0;
      cycle(1'b1, 1'b1, 32'h100);
      repeat (15) cycle(1'b1, 1'b0, '0);
      tests++;
      if (pops < 1) begin
         fails++;
         $display("FAIL redir_wait_progress: got %0d pops expected >=1", pops);
      end
   endtask

   task automatic test_redirect_rvalid();
      int n = 0;
      do_reset();
      lat = 2;
      cycle(1'b1, 1'b0, '0);
      while (!(mem_pend && mem_cnt == 0) && n < 20) begin
         cycle(1'b1, 1'b0, '0);
         n++;
      end
      tests++;
      if (!(mem_pend && mem_cnt == 0)) begin
         fails++;
         $display("FAIL redir_rvalid_timeout: got no response expected one");
      end
      pops = 0;
      cycle(1'b1, 1'b1, 32'h200);
      repeat (12) cycle(1'b1, 1'b0, '0);
      tests++;
      if (pops < 1) begin
         fails++;
         $display("FAIL redir_rvalid_progress: got %0d pops expected >=1", pops);
      end
   endtask

   task automatic test_reset_mid_wait();
      int n = 0;
      do_reset();
      lat = 6;
      while (accs < 2 && n < 30) begin
         cycle(1'b0, 1'b0, '0);
         n++;
      end
      tests++;
      if (accs < 2 || instr_valid !== 1'b1) begin
         fails++;
         $display("FAIL mid_wait_setup: got accs=%0d valid=%b expected 2/1", accs, instr_valid);
      end
      #1 reset = 1'b1;
      #1;
      tests++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0 || Instr !== 32'h0000_0013) begin
         fails++;
         $display("FAIL async_reset: got valid=%b req=%b instr=%h expected 0/0/00000013",
                  instr_valid, imem_req, Instr);
      end
      do_reset();
      repeat (6) cycle(1'b1, 1'b0, '0);
      tests++;
      if (accs < 1) begin
         fails++;
         $display("FAIL after_reset_fetch: got %0d requests expected >=1", accs);
      end
   endtask

   task automatic test_misalign();
      do_reset();
      cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 32'h102);
      cycle(1'b1, 1'b0, '0);
      pops = 0;
      repeat (10) cycle(1'b1, 1'b0, '0);
      tests++;
      if (pops < 1) begin
         fails++;
         $display("FAIL misalign_progress: got %0d pops expected >=1", pops);
      end
   endtask

   task automatic test_random();
      do_reset();
      rnd_ready = 1'b1;
      repeat (3000) begin
         lat = $urandom_range(1, 4);
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
               ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom);
      end
      tests++;
      if (pops < 100) begin
         fails++;
         $display("FAIL random_progress: got %0d pops expected >=100", pops);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_redirect_rvalid();
      test_reset_mid_wait();
      test_misalign();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
